serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder, LSB first, one bit per clock.
// Operands are captured on the accepting edge; the result registers only change on completion.
//
// state | meaning
// IDLE  | waiting for start, last result held on sum/cout/overflow
// RUN   | one operand bit processed per clock, counter selects the bit
// DONE  | result valid and done high for this one cycle; start here chains a new operation
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             bit_s, carry_s, last_s, accept_s;
    logic [WIDTH:0]   shifted_s;

    assign bit_s     = a_q[cnt_q] ^ b_q[cnt_q] ^ carry_q;
    assign carry_s   = (a_q[cnt_q] & b_q[cnt_q]) | (a_q[cnt_q] & carry_q) | (b_q[cnt_q] & carry_q);
    // The new bit enters at the top, so after WIDTH shifts the LSB sits at bit 0.
    assign shifted_s = {bit_s, acc_q};
    assign last_s    = (cnt_q == LAST);
    assign accept_s  = start && (state != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_s) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept_s) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            acc_q   <= shifted_s[WIDTH:1];
            carry_q <= carry_s;
            if (last_s) begin
                // carry_q here is the carry into the MSB
                sum      <= shifted_s[WIDTH:1];
                cout     <= carry_s;
                overflow <= carry_q ^ carry_s;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 1-bit instance driven with directed and random
// operations, compared against a plain-arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s8_start, s8_cin, s8_sub, s8_busy, s8_done, s8_cout, s8_ovf;
    logic [7:0] s8_a, s8_b, s8_sum;
    logic       s1_start, s1_cin, s1_sub, s1_busy, s1_done, s1_cout, s1_ovf;
    logic [0:0] s1_a, s1_b, s1_sum;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .a(s8_a), .b(s8_b), .cin(s8_cin), .sub(s8_sub),
        .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout), .overflow(s8_ovf)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin), .sub(s1_sub),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .overflow(s1_ovf)
    );

    int total = 0;
    int bad   = 0;

    logic [9:0] last8;
    logic [2:0] last1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Result from the arithmetic meaning of the operation, independent of any bit-serial detail.
    function automatic void ref_model(input int w, input logic [31:0] ua, input logic [31:0] ub,
                                      input logic ci, input logic s, output logic [31:0] rs,
                                      output logic rc, output logic rv);
        longint m, lim, full, sa, sb, v;
        m   = (longint'(1) << w) - 1;
        lim = longint'(1) << (w - 1);
        if (s) begin
            rs = 32'((longint'(ua) - longint'(ub)) & m);
            rc = (ua >= ub);
        end else begin
            full = longint'(ua) + longint'(ub) + longint'(ci);
            rs   = 32'(full & m);
            rc   = (full > m);
        end
        sa = (longint'(ua) >= lim) ? longint'(ua) - 2 * lim : longint'(ua);
        sb = (longint'(ub) >= lim) ? longint'(ub) - 2 * lim : longint'(ub);
        v  = s ? sa - sb : sa + sb + longint'(ci);
        rv = (v >= lim) || (v < -lim);
    endfunction

    // Caller is at a negedge. poke: RUN cycle index at which start is re-pulsed (-1 = none).
    // hold: leave the bench at the DONE negedge so the caller can chain the next operation.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s,
                       input int poke, input bit hold, input string tag);
        logic [31:0] rs;
        logic        rc, rv;
        ref_model(8, 32'(a), 32'(b), ci, s, rs, rc, rv);
        s8_a = a; s8_b = b; s8_cin = ci; s8_sub = s; s8_start = 1'b1;
        @(posedge clk);
        #1;
        s8_start = 1'b0;
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom); s8_sub = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val($sformatf("%s/busy%0d", tag, i), 32'(s8_busy), 32'd1);
            check_val($sformatf("%s/nodone%0d", tag, i), 32'(s8_done), 32'd0);
            check_val($sformatf("%s/held%0d", tag, i), 32'({s8_sum, s8_cout, s8_ovf}), 32'(last8));
            if (i == poke) begin
                s8_start = 1'b1;
                s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom); s8_sub = 1'($urandom);
            end else begin
                s8_start = 1'b0;
            end
        end
        @(negedge clk);
        check_val({tag, "/done"}, 32'(s8_done), 32'd1);
        check_val({tag, "/busy_end"}, 32'(s8_busy), 32'd0);
        check_val({tag, "/sum"}, 32'(s8_sum), rs);
        check_val({tag, "/cout"}, 32'(s8_cout), 32'(rc));
        check_val({tag, "/ovf"}, 32'(s8_ovf), 32'(rv));
        last8 = {rs[7:0], rc, rv};
        if (!hold) begin
            @(negedge clk);
            check_val({tag, "/pulse"}, 32'(s8_done), 32'd0);
            check_val({tag, "/idle"}, 32'(s8_busy), 32'd0);
            check_val({tag, "/kept"}, 32'({s8_sum, s8_cout, s8_ovf}), 32'(last8));
        end
    endtask

    task automatic op1(input logic a, input logic b, input logic ci, input logic s,
                       input bit hold, input string tag);
        logic [31:0] rs;
        logic        rc, rv;
        ref_model(1, 32'(a), 32'(b), ci, s, rs, rc, rv);
        s1_a = a; s1_b = b; s1_cin = ci; s1_sub = s; s1_start = 1'b1;
        @(posedge clk);
        #1;
        s1_start = 1'b0;
        s1_a = 1'($urandom); s1_b = 1'($urandom); s1_cin = 1'($urandom); s1_sub = 1'($urandom);
        @(negedge clk);
        check_val({tag, "/busy"}, 32'({s1_busy, s1_done}), 32'b10);
        check_val({tag, "/held"}, 32'({s1_sum, s1_cout, s1_ovf}), 32'(last1));
        @(negedge clk);
        check_val({tag, "/done"}, 32'({s1_busy, s1_done}), 32'b01);
        check_val({tag, "/res"}, 32'({s1_sum, s1_cout, s1_ovf}), 32'({rs[0], rc, rv}));
        last1 = {rs[0], rc, rv};
        if (!hold) begin
            @(negedge clk);
            check_val({tag, "/idle"}, 32'({s1_busy, s1_done}), 32'b00);
        end
    endtask

    initial begin
        logic [15:0] tbl;
        int          n;
        rst = 1'b1;
        s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0; s8_sub = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0; s1_sub = 1'b0;
        last8 = '0;
        last1 = '0;
        #1;
        check_val("reset8", 32'({s8_busy, s8_done, s8_sum, s8_cout, s8_ovf}), 32'd0);
        check_val("reset1", 32'({s1_busy, s1_done, s1_sum, s1_cout, s1_ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle8", 32'({s8_busy, s8_done}), 32'd0);

        op8(8'hFF, 8'h01, 1'b0, 1'b0, -1, 1'b0, "c1");
        op8(8'h7F, 8'h01, 1'b0, 1'b0, -1, 1'b0, "c2");
        op8(8'h05, 8'h07, 1'b1, 1'b1, -1, 1'b0, "c3a");
        op8(8'h07, 8'h05, 1'b0, 1'b1, -1, 1'b0, "c3b");
        op8(8'h3C, 8'h44, 1'b1, 1'b0, 2, 1'b1, "c4a");
        op8(8'h80, 8'h01, 1'b0, 1'b1, -1, 1'b0, "c4b");

        // Abort mid-operation: outputs must clear at once and no done may follow.
        s8_a = 8'hAA; s8_b = 8'h55; s8_cin = 1'b1; s8_sub = 1'b0; s8_start = 1'b1;
        @(posedge clk);
        #1;
        s8_start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("c5/clear", 32'({s8_busy, s8_done, s8_sum, s8_cout, s8_ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last8 = '0;
        last1 = '0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s8_done || s8_busy) n++;
        end
        check_val("c5/nodone", 32'(n), 32'd0);
        op8(8'h10, 8'h20, 1'b0, 1'b0, -1, 1'b0, "c5");

        tbl = 16'b00_01_01_10_01_10_10_11;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0], 1'b0, (i != 7), $sformatf("c6_%0d", i));
            check_val($sformatf("c6tbl_%0d", i), 32'({s1_cout, s1_sum}), 32'(tbl[15 - 2*i -: 2]));
        end

        for (int i = 0; i < 30; i++) begin
            int p;
            p = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), p,
                (i != 29) && ($urandom_range(0, 1) == 1), $sformatf("r8_%0d", i));
        end
        for (int i = 0; i < 12; i++) begin
            op1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                (i != 11) && ($urandom_range(0, 1) == 1), $sformatf("r1_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
